// File: rtl/jk_latch_monitor_if.sv
// Purpose: observation bundle between a J-K latch under test and its monitor.
// Latency: none, wires only.
// Backpressure: none; the latch pins are sampled every cycle, status is level/pulse.
// Signals:
//   start              1-cycle pulse that clears and arms the monitor
//   j, k, en           latch inputs as seen at the latch pins
//   q, qb              latch outputs as seen at the latch pins
//   state              monitor state, 0=IDLE 1=SYNC 2=TRACK 3=HOLD
//   mismatch           1-cycle pulse per failed check
//   fail               sticky failure flag since the last start
//   err_cnt            saturating count of failed checks
//   sample_cnt         saturating count of checks performed
// Modports: master = stimulus / latch side, slave = monitor side.
interface jk_latch_monitor_if #(
  parameter int CNT_W = 8
) ();
  logic             start;
  logic             j;
  logic             k;
  logic             en;
  logic             q;
  logic             qb;
  logic [1:0]       state;
  logic             mismatch;
  logic             fail;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] sample_cnt;

  modport master (
    output start, j, k, en, q, qb,
    input  state, mismatch, fail, err_cnt, sample_cnt
  );

  modport slave (
    input  start, j, k, en, q, qb,
    output state, mismatch, fail, err_cnt, sample_cnt
  );
endinterface

// File: rtl/jk_latch_monitor.sv
// Purpose: in-system checker for a level-sensitive J-K latch (expected-q model + q/qb complement check).
// Latency: latch pin change to mismatch pulse is 3 clk (2-flop sync + registered check).
// Backpressure: none; sampled every cycle, counters saturate instead of wrapping.
// Ports:
//   clk      rising-edge system clock
//   rst_n    asynchronous active-low reset, clears every register
//   mon      jk_latch_monitor_if.slave: start/j/k/en/q/qb in, state/mismatch/fail/err_cnt/sample_cnt out
module jk_latch_monitor #(
  parameter int CNT_W  = 8,
  parameter int SETTLE = 2
) (
  input logic               clk,
  input logic               rst_n,
  jk_latch_monitor_if.slave mon
);

  localparam int              HW        = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [HW-1:0]   SETTLE_LD = HW'(SETTLE);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    TRACK = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [HW-1:0]    hold_cnt;
  logic [HW-1:0]    hold_d;

  // Pin vector order: {j, k, en, q, qb}
  logic [4:0]       meta_r;
  logic [4:0]       sync_r;
  logic [2:0]       prev_jke;

  logic             s_j;
  logic             s_k;
  logic             s_en;
  logic             s_q;
  logic             s_qb;
  logic             change;

  logic             exp_q;
  logic             known;

  logic             chk_act;
  logic             q_bad;
  logic             c_bad;
  logic             chk_bad;

  logic             mismatch_r;
  logic             fail_r;
  logic [CNT_W-1:0] err_cnt_r;
  logic [CNT_W-1:0] sample_cnt_r;

  // ---------------------------------------------------------------------------
  // Synchronizers and change detection
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r   <= '0;
      sync_r   <= '0;
      prev_jke <= '0;
    end else begin
      meta_r   <= {mon.j, mon.k, mon.en, mon.q, mon.qb};
      sync_r   <= meta_r;
      prev_jke <= sync_r[4:2];
    end
  end

  assign s_j    = sync_r[4];
  assign s_k    = sync_r[3];
  assign s_en   = sync_r[2];
  assign s_q    = sync_r[1];
  assign s_qb   = sync_r[0];
  assign change = (sync_r[4:2] != prev_jke);

  // ---------------------------------------------------------------------------
  // Expected-q model of the latch, driven from synchronized inputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q <= 1'b0;
      known <= 1'b0;
    end else if (mon.start) begin
      known <= 1'b0;
    end else if (s_en) begin
      case ({s_j, s_k})
        2'b10: begin
          exp_q <= 1'b1;
          known <= 1'b1;
        end
        2'b01: begin
          exp_q <= 1'b0;
          known <= 1'b1;
        end
        // Both set while transparent: the latch races, q is undefined
        2'b11:   known <= 1'b0;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      hold_cnt <= '0;
    end else begin
      state_q  <= state_d;
      hold_cnt <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_cnt;
    if (mon.start) begin
      state_d = SYNC;
      hold_d  = '0;
    end else begin
      case (state_q)
        IDLE: ;
        SYNC: begin
          if (known) begin
            state_d = HOLD;
            hold_d  = SETTLE_LD;
          end
        end
        HOLD: begin
          if (change) begin
            hold_d = SETTLE_LD;
          end else if (hold_cnt <= HW'(1)) begin
            // Leaves as the count reaches zero, so HOLD lasts SETTLE cycles
            hold_d  = '0;
            state_d = known ? TRACK : SYNC;
          end else begin
            hold_d = hold_cnt - HW'(1);
          end
        end
        TRACK: begin
          if (!known) begin
            state_d = SYNC;
          end else if (change) begin
            state_d = HOLD;
            hold_d  = SETTLE_LD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Checks. The cycle in which a j/k/en change first appears is not compared
  // against exp_q: the model has not absorbed the change yet, while q may
  // already have moved.
  // ---------------------------------------------------------------------------
  assign chk_act = (state_q != IDLE);
  assign q_bad   = (state_q == TRACK) && known && !change && (s_q != exp_q);
  assign c_bad   = chk_act && (s_q == s_qb);
  assign chk_bad = q_bad || c_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_r   <= 1'b0;
      fail_r       <= 1'b0;
      err_cnt_r    <= '0;
      sample_cnt_r <= '0;
    end else if (mon.start) begin
      // start overrides a same-cycle failure: no pulse, nothing counted
      mismatch_r   <= 1'b0;
      fail_r       <= 1'b0;
      err_cnt_r    <= '0;
      sample_cnt_r <= '0;
    end else begin
      mismatch_r <= chk_bad;
      if (chk_act && (sample_cnt_r != CNT_MAX)) begin
        sample_cnt_r <= sample_cnt_r + CNT_W'(1);
      end
      if (chk_bad) begin
        fail_r <= 1'b1;
        if (err_cnt_r != CNT_MAX) begin
          err_cnt_r <= err_cnt_r + CNT_W'(1);
        end
      end
    end
  end

  assign mon.state      = state_q;
  assign mon.mismatch   = mismatch_r;
  assign mon.fail       = fail_r;
  assign mon.err_cnt    = err_cnt_r;
  assign mon.sample_cnt = sample_cnt_r;

endmodule
